// File: rtl/car_sensor_emulator.sv
// Two-beam car sensor waveform generator: emits timed enter/exit beam sequences on request.
// Optional reference occupancy count is enabled by defining CAR_EMU_OCC_COUNT_EN.
module car_sensor_emulator #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  input  logic             abort,
  output logic             a_btn,
  output logic             b_btn,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] occ_count
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int HW      = $clog2(MAX_CYC + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] GAP_LD  = HW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, CLR} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          dir_q, dir_d;
  logic          abrt_q, abrt_d;
  logic          a_q, a_d, b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

`ifdef CAR_EMU_OCC_COUNT_EN
  logic [CNT_W-1:0] occ_q;
  logic             occ_full, occ_empty;

  assign occ_full  = &occ_q;
  assign occ_empty = (occ_q == '0);
  // Refuse requests that would push the reference count past either end.
  assign req_ready = (state_q == IDLE) && (req_dir ? !occ_empty : !occ_full);
  assign occ_count = occ_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (done_d) begin
      if (!dir_q && !occ_full) begin
        occ_q <= occ_q + 1'b1;
      end else if (dir_q && !occ_empty) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end
`else
  assign req_ready = (state_q == IDLE);
  assign occ_count = '0;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dir_d     = dir_q;
    abrt_d    = abrt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = PH1;
          hold_d  = HOLD_LD;
          dir_d   = req_dir;
          abrt_d  = 1'b0;
        end
      end
      PH1, PH2, PH3: begin
        if (abort) begin
          state_d = CLR;
          hold_d  = GAP_LD;
          abrt_d  = 1'b1;
        end else if (hold_q == '0) begin
          hold_d = HOLD_LD;
          case (state_q)
            PH1:     state_d = PH2;
            PH2:     state_d = PH3;
            default: begin
              state_d = CLR;
              hold_d  = GAP_LD;
            end
          endcase
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      CLR: begin
        if (hold_q == '0) begin
          state_d = IDLE;
          hold_d  = '0;
          if (abrt_q) begin
            aborted_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Beams are registered from the next state so they change together with it.
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      PH1:     {a_d, b_d} = dir_d ? 2'b01 : 2'b10;
      PH2:     {a_d, b_d} = 2'b11;
      PH3:     {a_d, b_d} = dir_d ? 2'b10 : 2'b01;
      default: {a_d, b_d} = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      dir_q     <= 1'b0;
      abrt_q    <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      abrt_q    <= abrt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign a_btn   = a_q;
  assign b_btn   = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: doc/car_sensor_emulator.md
Name: car_sensor_emulator

Overview:
- Generates the two-beam sensor waveform (a_btn, b_btn) that a car produces when it enters or leaves the parking lot.
- It is the transmitter side of the car-parking sensor interface and drives the a_btn/b_btn inputs of the car-parking counter.
- Used in benches and on board (driven from push-buttons) to issue clean, timed enter/exit events on request.
- Optionally keeps its own reference occupancy count so results can be compared with the counter's led_counter.

Parameters:
- HOLD_CYCLES, 4, clock cycles each beam phase is held (min 1).
- GAP_CYCLES, 2, clock cycles of both-beams-clear after a sequence (min 1).
- CNT_W, 3, width of occupancy count (matches led_counter).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request to emit one car event.
- req_dir  input  1  0 = enter (a beam first), 1 = exit (b beam first); sampled with req_valid.
- req_ready  output  1  block can accept a request this cycle.
- abort  input  1  cancel the sequence in progress.
- a_btn  output  1  outer beam, 1 = blocked.
- b_btn  output  1  inner beam, 1 = blocked.
- busy  output  1  sequence in progress (state != IDLE).
- done  output  1  one-cycle pulse when a full sequence completes.
- aborted  output  1  one-cycle pulse when an aborted sequence returns to IDLE.
- occ_count  output  CNT_W  reference occupancy (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=IDLE, a_btn=b_btn=0, busy=0, done=0, aborted=0, occ_count=0, hold counter=0. Reset mid-sequence drops both beams at once; no done is emitted.
- All outputs are registered except req_ready, which is combinational from state (and from the count when the feature is enabled).
- States: IDLE, PH1, PH2, PH3, CLR.
- Beam pattern (a,b) for enter: PH1=10, PH2=11, PH3=01, CLR=00.
- Beam pattern (a,b) for exit: PH1=01, PH2=11, PH3=10, CLR=00.
- IDLE drives 00.
- Direction is latched at acceptance and held for the whole sequence.
- Acceptance: on a rising edge with req_valid & req_ready, state goes to PH1. The new beam values are visible the cycle after that edge.
- req_ready=1 only in IDLE. req_valid is ignored otherwise; requests are not queued.
- PH1, PH2 and PH3 each last exactly HOLD_CYCLES cycles. CLR lasts GAP_CYCLES cycles, then IDLE.
- A normal sequence is busy for 3*HOLD_CYCLES+GAP_CYCLES cycles.
- done=1 for exactly the first IDLE cycle after CLR. req_ready is also 1 in that cycle, so back-to-back requests are legal.
- abort is honoured in PH1–PH3 only (ignored in IDLE and CLR):
  - next state is CLR with a fresh GAP_CYCLES count;
  - beams go to 00;
  - at return to IDLE, aborted pulses for 1 cycle and done stays 0;
  - occ_count is unchanged.
- abort and an acceptance in the same IDLE cycle: the request is accepted and abort is ignored.
- Hold counter width: $clog2 of max(HOLD_CYCLES, GAP_CYCLES)+1. It reloads at every state change.

Optional Feature:
- Macro: CAR_EMU_OCC_COUNT_EN.
- Defined:
  - occ_count increments on a completed enter and decrements on a completed exit, updating in the done cycle.
  - Count saturates at 2^CNT_W-1 and 0.
  - req_ready is additionally forced 0 for a request that would overflow or underflow: an enter at full or an exit at 0 is not accepted and no beams move.
- Not defined: occ_count is tied to 0, and req_ready depends on state only.

Test Plan:
- HOLD=2, GAP=1; enter accepted at edge 0 -> (a,b) = 10 in cycles 1-2, 11 in cycles 3-4, 01 in cycles 5-6, 00 in cycle 7; done=1 in cycle 8 only; busy high in cycles 1-7; occ_count 0->1 in cycle 8 (feature on).
- Same timing with req_dir=1 -> 01, 11, 10, 00; occ_count 1->0.
- Second request held valid through a sequence -> not accepted until the done cycle; the next PH1 starts the cycle after done with no 00 gap beyond GAP_CYCLES.
- abort in cycle 3 (PH2) -> 00 in cycle 4; aborted=1 in cycle 5; done never asserts; occ_count unchanged.
- reset asserted asynchronously mid-PH2 -> a_btn=b_btn=0, busy=0, occ_count=0 with no clock edge; req_ready=1 after release.
- Feature on, occ_count=0, exit request -> req_ready=0, beams stay 00. After 7 enters, an 8th enter is refused and occ_count stays 7.
